// File: rtl/demux_1_2_32_reg_if.sv
// Handshake bundle for demux_1_2_32_reg: one valid/ready input port, two valid/ready output channels.
// master = word producer and channel consumers (the environment), slave = the demux itself.
interface demux_1_2_32_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );
endinterface

// File: rtl/demux_1_2_32_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry buffer per output channel.
// Optional per-channel delivery counters (cnt0/cnt1) are built when DEMUX_STATS_EN is defined.
module demux_1_2_32_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1_2_32_reg_if.slave    bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        state0_p1;
    ch_state_t        state1_p1;
    logic [WIDTH-1:0] data0_p1;
    logic [WIDTH-1:0] data1_p1;

    logic vld0_p1;
    logic vld1_p1;
    logic in_fire;
    logic take0;
    logic take1;
    logic drain0;
    logic drain1;

    assign vld0_p1 = (state0_p1 == FULL);
    assign vld1_p1 = (state1_p1 == FULL);

    // Only the selected channel's occupancy and consumer gate the input.
    assign bus.in_ready = bus.in_sel ? (~vld1_p1 | bus.out1_ready)
                                     : (~vld0_p1 | bus.out0_ready);

    assign in_fire = bus.in_valid & bus.in_ready;
    assign take0   = in_fire & ~bus.in_sel;
    assign take1   = in_fire &  bus.in_sel;
    assign drain0  = vld0_p1 & bus.out0_ready;
    assign drain1  = vld1_p1 & bus.out1_ready;

    // Input stage -> channel buffers (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            state0_p1 <= EMPTY;
            state1_p1 <= EMPTY;
            data0_p1  <= '0;
            data1_p1  <= '0;
        end else begin
            case (state0_p1)
                EMPTY: if (take0) begin
                    state0_p1 <= FULL;
                    data0_p1  <= bus.in_data;
                end
                FULL: if (take0) begin
                    data0_p1  <= bus.in_data;
                end else if (drain0) begin
                    state0_p1 <= EMPTY;
                end
                default: state0_p1 <= EMPTY;
            endcase

            case (state1_p1)
                EMPTY: if (take1) begin
                    state1_p1 <= FULL;
                    data1_p1  <= bus.in_data;
                end
                FULL: if (take1) begin
                    data1_p1  <= bus.in_data;
                end else if (drain1) begin
                    state1_p1 <= EMPTY;
                end
                default: state1_p1 <= EMPTY;
            endcase
        end
    end

    assign bus.out0_valid = vld0_p1;
    assign bus.out0_data  = data0_p1;
    assign bus.out1_valid = vld1_p1;
    assign bus.out1_data  = data1_p1;

`ifdef DEMUX_STATS_EN
    // Delivery counters wrap freely; they count consumer-side transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (drain0) cnt0 <= cnt0 + 1'b1;
            if (drain1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1_2_32_reg.sv
// Scoreboard bench for demux_1_2_32_reg: per-channel expected-word queues model the one-entry buffers.
module tb_demux_1_2_32_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;

    demux_1_2_32_reg_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    demux_1_2_32_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0 (cnt0),
        .cnt1 (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               exp_cnt0;
    int               exp_cnt1;
    int               n_checks;
    int               n_passed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_passed++;
    endtask

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic tick();
        logic full0, full1, exp_rdy, acc, dr0, dr1;
        #1;
        full0 = (q0.size() > 0);
        full1 = (q1.size() > 0);
        check("out0_valid", 32'(bus.out0_valid), 32'(full0));
        check("out1_valid", 32'(bus.out1_valid), 32'(full1));
        if (full0) check("out0_data", bus.out0_data, q0[0]);
        if (full1) check("out1_data", bus.out1_data, q1[0]);
        exp_rdy = bus.in_sel ? (!full1 || bus.out1_ready) : (!full0 || bus.out0_ready);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
`ifdef DEMUX_STATS_EN
        check("cnt0", 32'(cnt0), 32'(exp_cnt0));
        check("cnt1", 32'(cnt1), 32'(exp_cnt1));
`endif
        acc = bus.in_valid && exp_rdy;
        dr0 = full0 && bus.out0_ready;
        dr1 = full1 && bus.out1_ready;
        if (dr0) begin void'(q0.pop_front()); exp_cnt0 = (exp_cnt0 + 1) % (1 << CNT_W); end
        if (dr1) begin void'(q1.pop_front()); exp_cnt1 = (exp_cnt1 + 1) % (1 << CNT_W); end
        if (acc) begin
            if (bus.in_sel) q1.push_back(bus.in_data);
            else            q0.push_back(bus.in_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        #1;
        check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("rst_out0_data",  bus.out0_data, 32'd0);
        check("rst_out1_data",  bus.out1_data, 32'd0);
`ifdef DEMUX_STATS_EN
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        // Fill ch0 with DEADBEEF, then reset over a full buffer.
        drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);        tick();
        drive(1'b1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0);
        do_reset();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);        tick();

        // Steer a single word to ch1.
        drive(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Backpressure on ch0 must not stall ch1.
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold", bus.out0_data, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Simultaneous in/out on ch0, then a back-to-back stream.
        drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0); tick();
        for (int i = 2; i <= 9; i++) begin
            drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) tick();

        // Randomized traffic, including all-zero words and flapping in_sel while idle.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Reset with both channels full and a word on the input.
        drive(1'b1, 1'b0, 32'hAAAA0000, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 32'hBBBB1111, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();

`ifdef DEMUX_STATS_EN
        // 17 deliveries on ch1 wraps a 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) tick();
        #1;
        check("cnt1_wrap", 32'(cnt1), 32'd1);
        check("cnt0_idle", 32'(cnt0), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
